// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: transfer op encodings, FSM states
// and the default stack base.
package stack_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  localparam int SP_RESET_DEFAULT = 2047;

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_e;

endpackage

// File: rtl/stack_seq_unit.sv
// Multi-word PUSH/POP sequencer: owns the stack pointer, walks N memory words one
// per cycle, stalls upstream during the walk and rejects over/underflowing requests.
module stack_seq_unit
  import stack_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 4,
  parameter int SP_RESET  = SP_RESET_DEFAULT,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  input  logic [1:0]                  req_op,
  input  logic [CNT_W-1:0]            req_words,
  input  logic [MAX_WORDS*DATA_W-1:0] push_data,
  output logic                        stall_out,
  output logic                        pop_valid,
  output logic [MAX_WORDS*DATA_W-1:0] pop_data,
  output logic                        fault_ovf,
  output logic                        fault_udf,
  output logic [ADDR_W-1:0]           sp_out,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  output logic                        mem_re,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [AW1-1:0]   SP_BASE = AW1'(SP_RESET);
  localparam logic [CNT_W-1:0] MAX_N   = CNT_W'(MAX_WORDS);

  state_e                      state_q, state_d;
  logic [ADDR_W-1:0]           sp_q, sp_d;
  logic [CNT_W-1:0]            wordCnt_q, wordCnt_d;
  logic [CNT_W-1:0]            numWords_q, numWords_d;
  logic [1:0]                  op_q, op_d;
  logic [MAX_WORDS*DATA_W-1:0] pushData_q, pushData_d;
  logic [MAX_WORDS*DATA_W-1:0] asmData_q, asmData_d;

  logic                        idle, reqOk, accept, step, last, isPush, isPop;
  logic [AW1-1:0]              spWide, nWide;
  logic [1:0]                  curOp;
  logic [CNT_W-1:0]            curN, curK, wordIdx;
  logic [MAX_WORDS*DATA_W-1:0] curData;
  logic [DATA_W-1:0]           pushWord;

  // The acceptance cycle is itself step 0, so "current" values come straight
  // from the request then, and from the latched copies during XFER.
  always_comb begin
    idle      = (state_q == ST_IDLE) && !reset;
    spWide    = {1'b0, sp_q};
    nWide     = AW1'(req_words);
    reqOk     = req_valid && (req_op == OP_PUSH || req_op == OP_POP) &&
                (req_words != '0) && (req_words <= MAX_N);
    fault_ovf = idle && reqOk && (req_op == OP_PUSH) && (spWide + AW1'(1) < nWide);
    fault_udf = idle && reqOk && (req_op == OP_POP) && (spWide + nWide > SP_BASE);
    accept    = idle && reqOk && !fault_ovf && !fault_udf;
    step      = accept || ((state_q == ST_XFER) && !reset);
    curOp     = accept ? req_op    : op_q;
    curN      = accept ? req_words : numWords_q;
    curK      = accept ? '0        : wordCnt_q;
    curData   = accept ? push_data : pushData_q;
    isPush    = step && (curOp == OP_PUSH);
    isPop     = step && (curOp == OP_POP);
    last      = step && (curK == curN - CNT_W'(1));
    wordIdx   = curN - curK - CNT_W'(1);
  end

  always_comb begin
    pushWord = '0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      if (wordIdx == CNT_W'(i)) pushWord = curData[i*DATA_W +: DATA_W];
    end
    mem_we    = isPush;
    mem_re    = isPop;
    mem_addr  = isPop ? sp_q + ADDR_W'(1) : sp_q;
    mem_wdata = isPush ? pushWord : '0;
    stall_out = step && !last;
    pop_valid = isPop && last;
    sp_out    = sp_q;
    // Words above the current step are masked so stale assembly data never leaks.
    pop_data  = '0;
    if (pop_valid) begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        if (CNT_W'(i) < curK) pop_data[i*DATA_W +: DATA_W] = asmData_q[i*DATA_W +: DATA_W];
        else if (CNT_W'(i) == curK) pop_data[i*DATA_W +: DATA_W] = mem_rdata;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    wordCnt_d  = wordCnt_q;
    numWords_d = numWords_q;
    op_d       = op_q;
    pushData_d = pushData_q;
    asmData_d  = asmData_q;
    if (step) begin
      sp_d = isPush ? sp_q - ADDR_W'(1) : sp_q + ADDR_W'(1);
      if (last) begin
        state_d   = ST_IDLE;
        wordCnt_d = '0;
      end else begin
        state_d   = ST_XFER;
        wordCnt_d = curK + CNT_W'(1);
      end
    end
    if (accept) begin
      op_d       = req_op;
      numWords_d = req_words;
      pushData_d = push_data;
    end
    if (isPop && !last) begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        if (curK == CNT_W'(i)) asmData_d[i*DATA_W +: DATA_W] = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sp_q       <= ADDR_W'(SP_RESET);
      wordCnt_q  <= '0;
      numWords_q <= '0;
      op_q       <= OP_NONE;
      pushData_q <= '0;
      asmData_q  <= '0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      wordCnt_q  <= wordCnt_d;
      numWords_q <= numWords_d;
      op_q       <= op_d;
      pushData_q <= pushData_d;
      asmData_q  <= asmData_d;
    end
  end

endmodule

// File: tb/tb_stack_seq_unit.sv
// Self-checking bench for stack_seq_unit: a transaction-level stack model predicts
// every cycle's outputs, with directed boundary cases and randomized traffic.
module tb_stack_seq_unit;
  import stack_pkg::*;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 12;
  localparam int MAX_WORDS = 4;
  localparam int SP_RESET  = 2047;
  localparam int CNT_W     = 3;
  localparam int PW        = MAX_WORDS * DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic [1:0]        req_op = OP_NONE;
  logic [CNT_W-1:0]  req_words = '0;
  logic [PW-1:0]     push_data = '0;
  logic              stall_out, pop_valid, fault_ovf, fault_udf, mem_we, mem_re;
  logic [PW-1:0]     pop_data;
  logic [ADDR_W-1:0] sp_out, mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  typedef struct packed {
    logic              stall;
    logic              popValid;
    logic              ovf;
    logic              udf;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] sp;
    logic [DATA_W-1:0] wdata;
    logic [PW-1:0]     popData;
  } exp_t;

  exp_t              expQ[$];
  exp_t              cmpE;
  int                checks = 0;
  int                errors = 0;
  int                modelSp;
  logic [DATA_W-1:0] tbMem  [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] refMem [0:(1<<ADDR_W)-1];

  stack_seq_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS),
    .SP_RESET(SP_RESET), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_words(req_words), .push_data(push_data), .stall_out(stall_out),
    .pop_valid(pop_valid), .pop_data(pop_data), .fault_ovf(fault_ovf),
    .fault_udf(fault_udf), .sp_out(sp_out), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behaves as the data memory: synchronous write, combinational read.
  always @(posedge clk) if (mem_we) tbMem[mem_addr] <= mem_wdata;
  assign mem_rdata = tbMem[mem_addr];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t idleExp();
    exp_t e;
    e = '0;
    e.addr = ADDR_W'(modelSp);
    e.sp   = ADDR_W'(modelSp);
    return e;
  endfunction

  task automatic driveCycle(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] n,
                            input logic [PW-1:0] d, input exp_t e);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = v;
    req_op    = op;
    req_words = n;
    push_data = d;
    expQ.push_back(e);
  endtask

  task automatic resetCycles(input int c);
    for (int i = 0; i < c; i++) begin
      @(negedge clk);
      reset     = 1'b1;
      req_valid = 1'b0;
      req_op    = OP_NONE;
      req_words = '0;
      push_data = '0;
      modelSp   = SP_RESET;
      expQ.push_back(idleExp());
    end
  endtask

  // Model: a request is judged against the stack rules and expanded into the
  // per-cycle outputs it must produce; abortAt stops issuing steps early.
  task automatic applyStimulus(input logic v, input logic [1:0] op, input int n,
                               input logic [PW-1:0] d, input bit noise, input int abortAt);
    exp_t              e;
    logic [PW-1:0]     acc;
    logic [DATA_W-1:0] w;
    bit                ok;
    ok = v && (op == OP_PUSH || op == OP_POP) && n >= 1 && n <= MAX_WORDS;
    e  = idleExp();
    if (ok && op == OP_PUSH && modelSp < n - 1) begin
      e.ovf = 1'b1;
      driveCycle(v, op, CNT_W'(n), d, e);
    end else if (ok && op == OP_POP && modelSp + n > SP_RESET) begin
      e.udf = 1'b1;
      driveCycle(v, op, CNT_W'(n), d, e);
    end else if (!ok) begin
      driveCycle(v, op, CNT_W'(n), d, e);
    end else begin
      acc = '0;
      for (int k = 0; k < n; k++) begin
        if (k == abortAt) return;
        e       = '0;
        e.stall = (k < n - 1);
        e.sp    = ADDR_W'(modelSp);
        if (op == OP_PUSH) begin
          w       = d[(n-1-k)*DATA_W +: DATA_W];
          e.we    = 1'b1;
          e.addr  = ADDR_W'(modelSp);
          e.wdata = w;
          refMem[modelSp] = w;
          modelSp--;
        end else begin
          e.re   = 1'b1;
          e.addr = ADDR_W'(modelSp + 1);
          w      = refMem[modelSp + 1];
          acc[k*DATA_W +: DATA_W] = w;
          modelSp++;
          if (k == n - 1) begin
            e.popValid = 1'b1;
            e.popData  = acc;
          end
        end
        if (k == 0) driveCycle(v, op, CNT_W'(n), d, e);
        else if (noise) driveCycle(1'($urandom), 2'($urandom), 3'($urandom), PW'({$urandom, $urandom}), e);
        else driveCycle(1'b0, OP_NONE, '0, '0, e);
      end
    end
  endtask

  // Every driven cycle has one expectation; it is checked mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        cmpE = expQ.pop_front();
        checkOutput("stall", 64'(stall_out), 64'(cmpE.stall));
        checkOutput("popValid", 64'(pop_valid), 64'(cmpE.popValid));
        checkOutput("ovf", 64'(fault_ovf), 64'(cmpE.ovf));
        checkOutput("udf", 64'(fault_udf), 64'(cmpE.udf));
        checkOutput("we", 64'(mem_we), 64'(cmpE.we));
        checkOutput("re", 64'(mem_re), 64'(cmpE.re));
        checkOutput("addr", 64'(mem_addr), 64'(cmpE.addr));
        checkOutput("sp", 64'(sp_out), 64'(cmpE.sp));
        if (!cmpE.re) checkOutput("wdata", 64'(mem_wdata), 64'(cmpE.wdata));
        if (cmpE.popValid) checkOutput("popData", pop_data, cmpE.popData);
      end
    end
  end

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      tbMem[a]  = DATA_W'($urandom);
      refMem[a] = tbMem[a];
    end
    modelSp = SP_RESET;
    resetCycles(2);
    #3;
    checkOutput("rstSp", 64'(sp_out), 64'd2047);
    checkOutput("rstPopData", pop_data, 64'd0);
    checkOutput("rstOuts", 64'({stall_out, pop_valid, fault_ovf, fault_udf, mem_we, mem_re}), 64'd0);

    applyStimulus(1'b1, OP_PUSH, 2, 64'h1234ABCD, 1'b0, -1);
    applyStimulus(1'b0, OP_NONE, 0, '0, 1'b0, -1);
    #3;
    checkOutput("litMem2047", 64'(tbMem[2047]), 64'h1234);
    checkOutput("litMem2046", 64'(tbMem[2046]), 64'hABCD);
    checkOutput("litSpPush", 64'(sp_out), 64'd2045);

    applyStimulus(1'b1, OP_POP, 2, '0, 1'b0, -1);
    #3;
    checkOutput("litPopValid", 64'(pop_valid), 64'd1);
    checkOutput("litPopData", pop_data, 64'h1234ABCD);
    applyStimulus(1'b0, OP_NONE, 0, '0, 1'b0, -1);
    #3;
    checkOutput("litSpPop", 64'(sp_out), 64'd2047);

    applyStimulus(1'b1, OP_POP, 1, '0, 1'b0, -1);
    #3;
    checkOutput("litUdf", 64'(fault_udf), 64'd1);
    checkOutput("litUdfNoRe", 64'(mem_re), 64'd0);

    applyStimulus(1'b1, OP_PUSH, 4, 64'h0004_0003_0002_0001, 1'b0, -1);
    applyStimulus(1'b0, OP_NONE, 0, '0, 1'b0, -1);
    #3;
    checkOutput("litMax2047", 64'(tbMem[2047]), 64'h0004);
    checkOutput("litMax2044", 64'(tbMem[2044]), 64'h0001);
    checkOutput("litSpMax", 64'(sp_out), 64'd2043);

    applyStimulus(1'b1, OP_PUSH, 4, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1);
    resetCycles(1);
    #3;
    checkOutput("litRstWe", 64'(mem_we), 64'd0);
    checkOutput("litRstSp", 64'(sp_out), 64'd2047);
    applyStimulus(1'b1, OP_POP, 1, '0, 1'b0, -1);

    applyStimulus(1'b1, OP_PUSH, 0, 64'h1111, 1'b0, -1);
    applyStimulus(1'b1, OP_POP, 5, 64'h2222, 1'b0, -1);
    applyStimulus(1'b1, 2'b11, 2, 64'h3333, 1'b0, -1);
    applyStimulus(1'b1, OP_NONE, 2, 64'h4444, 1'b0, -1);
    applyStimulus(1'b1, OP_PUSH, 3, 64'h0005_0006_0007_0008, 1'b1, -1);

    for (int t = 0; t < 400; t++) begin
      applyStimulus(1'($urandom_range(0, 9) != 0), 2'($urandom), $urandom_range(0, 5),
                    PW'({$urandom, $urandom}), 1'b1, -1);
    end

    resetCycles(1);
    for (int t = 0; t < 511; t++) applyStimulus(1'b1, OP_PUSH, 4, PW'({$urandom, $urandom}), 1'b0, -1);
    applyStimulus(1'b1, OP_PUSH, 1, 64'h0000_0000_0000_7777, 1'b0, -1);
    applyStimulus(1'b1, OP_PUSH, 4, 64'h0009_0009_0009_0009, 1'b0, -1);
    #3;
    checkOutput("litOvf", 64'(fault_ovf), 64'd1);
    checkOutput("litOvfNoWe", 64'(mem_we), 64'd0);
    checkOutput("litOvfSp", 64'(sp_out), 64'd2);
    applyStimulus(1'b1, OP_PUSH, 2, 64'h0000_0000_00AA_00BB, 1'b0, -1);
    applyStimulus(1'b1, OP_PUSH, 2, 64'h0000_0000_00CC_00DD, 1'b0, -1);
    applyStimulus(1'b1, OP_POP, 2, '0, 1'b0, -1);
    #3;
    checkOutput("litBottomPop", pop_data, 64'h0000_0000_00AA_00BB);

    for (int t = 0; t < 3; t++) applyStimulus(1'b0, OP_NONE, 0, '0, 1'b0, -1);
    @(negedge clk);
    #4;
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
